load_store_unit: RTL and testbench

Sequential front end for the byte-addressed, big-endian 1024-byte data memory of the ARMv8 single-cycle core. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It drives the data memory's Address, WriteData, MemoryRead and MemoryWrite inputs and handles that memory's one-cycle registered read latency. It also supports byte, halfword and word accesses: loads are extracted with sign or zero extension, and narrow stores are performed as a read-modify-write of the containing doubleword.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Sequential load/store front end for a big-endian 1 KiB data memory with one-cycle read latency.
// Optional natural-alignment fault checking is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit #(
   parameter logic [63:0] MAX_ADDR = 64'd1016
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [63:0] ReqAddr,
   input  logic [63:0] ReqWData,
   output logic        RespValid,
   output logic [63:0] RespData,
   output logic        RespFault,
   output logic [63:0] MemAddress,
   output logic [63:0] MemWriteData,
   output logic        MemoryRead,
   output logic        MemoryWrite,
   input  logic [63:0] MemReadData
);

   localparam int unsigned DW = 64;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_RESP
   } state_t;

   state_t state, next_state;

   logic          rq_write;
   logic          rq_signed;
   logic [1:0]    rq_size;
   logic [DW-1:0] rq_wdata;

   logic          misalign_c;
   logic          fault_c;
   logic [DW-1:0] load_data_c;
   logic [DW-1:0] merge_data_c;

   logic          ready_d;
   logic          resp_valid_d;
   logic          resp_fault_d;
   logic          mem_read_d;
   logic          mem_write_d;
   logic [DW-1:0] resp_data_d;
   logic [DW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;

`ifdef LSU_ALIGN_CHECK_EN
   // Natural alignment: the low log2(N) address bits must be zero.
   always_comb begin
      misalign_c = 1'b0;
      case (ReqSize)
         SZ_H:    misalign_c = ReqAddr[0];
         SZ_W:    misalign_c = |ReqAddr[1:0];
         SZ_D:    misalign_c = |ReqAddr[2:0];
         default: misalign_c = 1'b0;
      endcase
   end
`else
   assign misalign_c = 1'b0;
`endif

   assign fault_c = (ReqAddr > MAX_ADDR) || misalign_c;

   // The addressed bytes sit at the top of the returned word; right-justify and extend.
   always_comb begin
      load_data_c = MemReadData;
      case (rq_size)
         SZ_B:    load_data_c = {{56{rq_signed & MemReadData[63]}}, MemReadData[63:56]};
         SZ_H:    load_data_c = {{48{rq_signed & MemReadData[63]}}, MemReadData[63:48]};
         SZ_W:    load_data_c = {{32{rq_signed & MemReadData[63]}}, MemReadData[63:32]};
         default: load_data_c = MemReadData;
      endcase
   end

   // Narrow store: overlay the low store bytes onto the top of the read-back doubleword.
   always_comb begin
      merge_data_c = rq_wdata;
      case (rq_size)
         SZ_B:    merge_data_c = {rq_wdata[7:0],  MemReadData[55:0]};
         SZ_H:    merge_data_c = {rq_wdata[15:0], MemReadData[47:0]};
         SZ_W:    merge_data_c = {rq_wdata[31:0], MemReadData[31:0]};
         default: merge_data_c = rq_wdata;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state plus next value of every registered output.
   always_comb begin
      next_state   = state;
      ready_d      = 1'b0;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_data_d  = '0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = MemAddress;
      mem_wdata_d  = MemWriteData;
      case (state)
         S_IDLE: begin
            ready_d = 1'b1;
            if (ReqValid) begin
               ready_d    = 1'b0;
               mem_addr_d = ReqAddr;
               if (fault_c) begin
                  next_state   = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else if (ReqWrite && (ReqSize == SZ_D)) begin
                  next_state  = S_WR;
                  mem_write_d = 1'b1;
                  mem_wdata_d = ReqWData;
               end else begin
                  next_state = S_RD;
                  mem_read_d = 1'b1;
               end
            end
         end
         S_RD: begin
            next_state = S_WAIT;
         end
         S_WAIT: begin
            if (rq_write) begin
               next_state  = S_WR;
               mem_write_d = 1'b1;
               mem_wdata_d = merge_data_c;
            end else begin
               next_state   = S_RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = load_data_c;
            end
         end
         S_WR: begin
            next_state   = S_RESP;
            resp_valid_d = 1'b1;
         end
         S_RESP: begin
            next_state = S_IDLE;
            ready_d    = 1'b1;
         end
         default: begin
            next_state = S_IDLE;
            ready_d    = 1'b1;
         end
      endcase
   end

   // Request fields held for the whole access.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rq_write  <= 1'b0;
         rq_signed <= 1'b0;
         rq_size   <= SZ_B;
         rq_wdata  <= '0;
      end else if ((state == S_IDLE) && ReqValid) begin
         rq_write  <= ReqWrite;
         rq_signed <= ReqSigned;
         rq_size   <= ReqSize;
         rq_wdata  <= ReqWData;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ReqReady     <= 1'b1;
         RespValid    <= 1'b0;
         RespFault    <= 1'b0;
         RespData     <= '0;
         MemoryRead   <= 1'b0;
         MemoryWrite  <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
      end else begin
         ReqReady     <= ready_d;
         RespValid    <= resp_valid_d;
         RespFault    <= resp_fault_d;
         RespData     <= resp_data_d;
         MemoryRead   <= mem_read_d;
         MemoryWrite  <= mem_write_d;
         MemAddress   <= mem_addr_d;
         MemWriteData <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-array memory reference model.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
module tb_load_store_unit;

   logic        Clk;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqSigned;
   logic [63:0] ReqAddr;
   logic [63:0] ReqWData;
   logic        RespValid;
   logic [63:0] RespData;
   logic        RespFault;
   logic [63:0] MemAddress;
   logic [63:0] MemWriteData;
   logic        MemoryRead;
   logic        MemoryWrite;
   logic [63:0] MemReadData;

   load_store_unit dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqWrite     (ReqWrite),
      .ReqSize      (ReqSize),
      .ReqSigned    (ReqSigned),
      .ReqAddr      (ReqAddr),
      .ReqWData     (ReqWData),
      .RespValid    (RespValid),
      .RespData     (RespData),
      .RespFault    (RespFault),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemoryRead   (MemoryRead),
      .MemoryWrite  (MemoryWrite),
      .MemReadData  (MemReadData)
   );

   typedef struct {
      string       name;
      logic        fault;
      logic [63:0] data;
      int          acc;
      int          lat;
      int          rd_rel;
      int          wr_rel;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] ref_mem [0:1023];
   logic [7:0] mem     [0:1023];
   bit         mem_init = 1'b0;
   int         cyc      = 0;
   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         rd_cnt   = 0;
   int         wr_cnt   = 0;
   int         rd_edge  = 0;
   int         wr_edge  = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Data memory: big-endian, 8 bytes per access, registered read.
   always @(posedge Clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
         mem_init <= 1'b1;
      end else begin
         if (MemoryWrite)
            for (int i = 0; i < 8; i++)
               mem[10'(MemAddress[9:0] + 10'(i))] <= MemWriteData[63-8*i -: 8];
         if (MemoryRead)
            for (int i = 0; i < 8; i++)
               MemReadData[63-8*i -: 8] <= mem[10'(MemAddress[9:0] + 10'(i))];
      end
   end

   function automatic logic ref_fault(input logic [63:0] a, input int n);
      logic f;
      f = (a > 64'd1016);
`ifdef LSU_ALIGN_CHECK_EN
      if ((a % 64'(n)) != 64'd0) f = 1'b1;
`endif
      return f;
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input logic sg);
      logic [63:0] v;
      int          base;
      v    = '0;
      base = int'(a[9:0]);
      for (int i = 0; i < n; i++) v = {v[55:0], ref_mem[base + i]};
      if (sg && (n < 8) && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic void ref_store(input logic [63:0] a, input int n, input logic [63:0] d);
      int base;
      base = int'(a[9:0]);
      for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*(n-1-i) +: 8];
   endfunction

   // Monitor: strobe bookkeeping plus response checking against the scoreboard queue.
   always @(negedge Clk) begin
      if (!Reset) begin
         chk("rd_wr_exclusive", 64'(MemoryRead & MemoryWrite), 64'd0);
         if (MemoryRead) begin
            rd_cnt++;
            rd_edge = cyc + 1;
         end
         if (MemoryWrite) begin
            wr_cnt++;
            wr_edge = cyc + 1;
         end
         if (RespValid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", 64'(RespValid), 64'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk({mon_e.name, "_fault"}, 64'(RespFault), 64'(mon_e.fault));
               chk({mon_e.name, "_data"}, RespData, mon_e.data);
               chk({mon_e.name, "_latency"}, 64'(cyc + 1 - mon_e.acc), 64'(mon_e.lat));
               chk({mon_e.name, "_rd_count"}, 64'(rd_cnt), 64'(mon_e.rd_rel > 0));
               chk({mon_e.name, "_wr_count"}, 64'(wr_cnt), 64'(mon_e.wr_rel > 0));
               if (mon_e.rd_rel > 0)
                  chk({mon_e.name, "_rd_cycle"}, 64'(rd_edge - mon_e.acc), 64'(mon_e.rd_rel));
               if (mon_e.wr_rel > 0)
                  chk({mon_e.name, "_wr_cycle"}, 64'(wr_edge - mon_e.acc), 64'(mon_e.wr_rel));
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic use_k, input logic [63:0] k);
      exp_t e;
      int   n;
      int   guard;
      n = 1 << int'(sz);
      @(posedge Clk); #1;
      ReqValid  = 1'b1;
      ReqWrite  = w;
      ReqSize   = sz;
      ReqSigned = sg;
      ReqAddr   = a;
      ReqWData  = d;
      guard     = 0;
      @(negedge Clk);
      while (!ReqReady && guard < 20) begin
         @(negedge Clk);
         guard++;
      end
      if (!ReqReady) begin
         chk({nm, "_accept_timeout"}, 64'(ReqReady), 64'd1);
         ReqValid = 1'b0;
         return;
      end
      e.name   = nm;
      e.acc    = cyc + 1;
      e.fault  = ref_fault(a, n);
      e.data   = '0;
      e.rd_rel = 0;
      e.wr_rel = 0;
      if (e.fault) begin
         e.lat = 1;
      end else if (!w) begin
         e.lat    = 3;
         e.rd_rel = 1;
         e.data   = use_k ? k : ref_load(a, n, sg);
      end else begin
         ref_store(a, n, d);
         if (n == 8) begin
            e.lat    = 2;
            e.wr_rel = 1;
         end else begin
            e.lat    = 4;
            e.rd_rel = 1;
            e.wr_rel = 3;
         end
      end
      sb_q.push_back(e);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge Clk);
      while ((sb_q.size() != 0 || !ReqReady) && g < 100) begin
         @(negedge Clk);
         g++;
      end
      chk("drain_pending", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] d;
      logic [1:0]  sz;
      logic        w;
      logic        sg;
      int          n;

      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
      Reset     = 1'b1;
      ReqValid  = 1'b0;
      ReqWrite  = 1'b0;
      ReqSize   = 2'd0;
      ReqSigned = 1'b0;
      ReqAddr   = '0;
      ReqWData  = '0;

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("reset_ReqReady", 64'(ReqReady), 64'd1);
      chk("reset_RespValid", 64'(RespValid), 64'd0);
      chk("reset_RespFault", 64'(RespFault), 64'd0);
      chk("reset_MemoryRead", 64'(MemoryRead), 64'd0);
      chk("reset_MemoryWrite", 64'(MemoryWrite), 64'd0);
      chk("reset_RespData", RespData, 64'd0);
      chk("reset_MemAddress", MemAddress, 64'd0);
      chk("reset_MemWriteData", MemWriteData, 64'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      issue("st_d16", 1'b1, 2'd3, 1'b0, 64'd16, 64'h1122334455667788, 1'b0, '0);
      issue("ld_d16", 1'b0, 2'd3, 1'b0, 64'd16, '0, 1'b1, 64'h1122334455667788);
      issue("st_b17", 1'b1, 2'd0, 1'b0, 64'd17, 64'hDEADBEEFCAFE00AB, 1'b0, '0);
      issue("ld_d16_rmw", 1'b0, 2'd3, 1'b0, 64'd16, '0, 1'b1, 64'h11AB334455667788);
      issue("ld_b17_s", 1'b0, 2'd0, 1'b1, 64'd17, '0, 1'b1, 64'hFFFFFFFFFFFFFFAB);
      issue("ld_b17_u", 1'b0, 2'd0, 1'b0, 64'd17, '0, 1'b1, 64'h00000000000000AB);
      issue("ld_w16_s", 1'b0, 2'd2, 1'b1, 64'd16, '0, 1'b1, 64'h0000000011AB3344);
      issue("ld_d1017", 1'b0, 2'd3, 1'b0, 64'd1017, '0, 1'b0, '0);
      issue("ld_h17_u", 1'b0, 2'd1, 1'b0, 64'd17, '0, 1'b1, 64'h000000000000AB33);
      issue("ld_d1016", 1'b0, 2'd3, 1'b0, 64'd1016, '0, 1'b0, '0);
      issue("st_d1017", 1'b1, 2'd3, 1'b0, 64'd1017, 64'h0123456789ABCDEF, 1'b0, '0);
      wait_idle();

      // Reset while a narrow store is in WAIT: nothing may reach memory.
      @(posedge Clk); #1;
      ReqValid  = 1'b1;
      ReqWrite  = 1'b1;
      ReqSize   = 2'd0;
      ReqSigned = 1'b0;
      ReqAddr   = 64'd16;
      ReqWData  = 64'h5A;
      @(negedge Clk);
      chk("rst_ready_before", 64'(ReqReady), 64'd1);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_ready_after", 64'(ReqReady), 64'd1);
      repeat (6) @(negedge Clk);
      chk("rst_no_write", 64'(wr_cnt), 64'd0);
      chk("rst_one_read", 64'(rd_cnt), 64'd1);
      chk("rst_no_resp", 64'(sb_q.size()), 64'd0);
      rd_cnt = 0;
      wr_cnt = 0;
      issue("ld_d16_after_rst", 1'b0, 2'd3, 1'b0, 64'd16, '0, 1'b1, 64'h11AB334455667788);

      for (int t = 0; t < 300; t++) begin
         sz = 2'($urandom_range(0, 3));
         n  = 1 << int'(sz);
         w  = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         d  = {$urandom, $urandom};
         case ($urandom_range(0, 9))
            0:       a = {$urandom, $urandom};
            1:       a = 64'($urandom_range(1008, 1030));
            default: a = 64'($urandom_range(0, 1016));
         endcase
         if ($urandom_range(0, 1) == 1) a = a & ~(64'(n) - 64'd1);
         issue("rand", w, sz, sg, a, d, 1'b0, '0);
         repeat ($urandom_range(0, 3)) @(posedge Clk);
      end

      wait_idle();
      repeat (3) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
